// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: FSM states,
// major opcodes, datapath mux selects and the opcode-class bit positions.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_JUMP = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_OP_ADD       = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH    = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT     = 2'b10;
  localparam logic [1:0] ALU_OP_FUNCT_IMM = 2'b11;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_REG   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  // Bit positions inside the one-hot opcode class vector.
  localparam int CLS_R      = 0;
  localparam int CLS_I      = 1;
  localparam int CLS_LOAD   = 2;
  localparam int CLS_STORE  = 3;
  localparam int CLS_BRANCH = 4;
  localparam int CLS_JAL    = 5;
  localparam int CLS_JALR   = 6;
  localparam int CLS_SYSTEM = 7;
  localparam int CLS_BAD    = 8;
  localparam int CLS_W      = 9;

  typedef logic [CLS_W-1:0] op_class_t;

endpackage

// File: rtl/rv_opcode_class.sv
// Combinational opcode decoder: exactly one class bit is set for any
// opcode; anything outside the supported set lands in CLS_BAD.
module rv_opcode_class
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  // One-hot class lookup.
  always_comb begin
    op_class = '0;
    case (opcode)
      OP_R:      op_class[CLS_R]      = 1'b1;
      OP_I:      op_class[CLS_I]      = 1'b1;
      OP_LOAD:   op_class[CLS_LOAD]   = 1'b1;
      OP_STORE:  op_class[CLS_STORE]  = 1'b1;
      OP_BRANCH: op_class[CLS_BRANCH] = 1'b1;
      OP_JAL:    op_class[CLS_JAL]    = 1'b1;
      OP_JALR:   op_class[CLS_JALR]   = 1'b1;
      OP_SYSTEM: op_class[CLS_SYSTEM] = 1'b1;
      default:   op_class[CLS_BAD]    = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Control FSM for the shared multi-cycle RV32I datapath. Outputs are Moore
// except the IF/MEM handshake strobes (mem_ready) and the branch pc_write
// (bcond), which are Mealy. Handshake: a memory request (mem_read or
// mem_write) is held with a constant address select until the cycle in
// which mem_ready is high; that cycle completes the access.
module multi_cycle_control
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       halt_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       is_halted
);

  state_t    state_q, state_d;
  op_class_t cls;

  rv_opcode_class u_class (
    .opcode   (opcode),
    .op_class (cls)
  );

  // State register; reset always returns to fetch.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IF;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: if (mem_ready) state_d = S_ID;
      S_ID: begin
        if (cls[CLS_SYSTEM])   state_d = halt_req ? S_HALT : S_IF;
        else if (cls[CLS_JAL]) state_d = S_JUMP;
        else if (cls[CLS_BAD]) state_d = S_IF;
        else                   state_d = S_EX;
      end
      S_EX: begin
        if (cls[CLS_R] || cls[CLS_I])             state_d = S_WB;
        else if (cls[CLS_LOAD] || cls[CLS_STORE]) state_d = S_MEM;
        else if (cls[CLS_JALR])                   state_d = S_JUMP;
        else                                      state_d = S_IF;
      end
      S_JUMP: state_d = S_WB;
      S_MEM:  if (mem_ready) state_d = cls[CLS_LOAD] ? S_WB : S_IF;
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Output decode; strobes and the halt flag are suppressed during reset.
  always_comb begin
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_REG;
    alu_op     = ALU_OP_ADD;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    is_halted  = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_ID: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_IMM;
        instr_done = (cls[CLS_SYSTEM] && !halt_req) || cls[CLS_BAD];
      end
      S_EX: begin
        alu_src_a = SRC_A_REG;
        if (cls[CLS_R]) begin
          alu_op = ALU_OP_FUNCT;
        end else if (cls[CLS_I]) begin
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_OP_FUNCT_IMM;
        end else if (cls[CLS_BRANCH]) begin
          alu_op     = ALU_OP_BRANCH;
          pc_write   = bcond;
          pc_source  = 1'b1;
          instr_done = 1'b1;
        end else begin
          alu_src_b = SRC_B_IMM;
        end
      end
      S_JUMP: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
        pc_source = 1'b1;
      end
      S_MEM: begin
        i_or_d     = 1'b1;
        mem_read   = cls[CLS_LOAD];
        mem_write  = cls[CLS_STORE];
        instr_done = mem_ready && cls[CLS_STORE];
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = cls[CLS_LOAD];
        instr_done = 1'b1;
      end
      S_HALT: is_halted = 1'b1;
      default: ;
    endcase
    if (!reset_n) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      is_halted  = 1'b0;
    end
  end

endmodule
